mem_stage: RTL and testbench

Memory-access stage of the five-stage pipeline. It performs data-memory loads and stores from the EX/MEM control and data bundle, then registers the result into the MEM/WB pipeline register. That register directly feeds the write-back stage with `mem_to_reg`, loaded data, ALU address/result, destination register and write enable. Stall, flush and misaligned-access handling all live here.

---
 rtl/mem_stage.sv | 162 ++++++++++++++++
 tb/tb_mem_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: data-memory loads/stores plus the MEM/WB pipeline register.
// Define MEM_BYTE_ACCESS_EN for byte/half accesses; otherwise every access is a full word.
module mem_stage #(
    parameter int ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] alu_result,
    input  logic [31:0] write_data,
    input  logic [4:0]  rd_in,
    input  logic        reg_write_in,
    input  logic        mem_to_reg_in,
    output logic [31:0] read_data,
    output logic [31:0] alu_out,
    output logic [4:0]  rd_out,
    output logic        reg_write_out,
    output logic        mem_to_reg_out,
    output logic        misaligned
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [31:0]          mem_q [DEPTH];
    logic [ADDR_BITS-1:0] word_idx;
    logic [31:0]          rd_word;
    logic                 access;
    logic                 misaligned_now;
    logic [3:0]           byte_en;
    logic [31:0]          store_word;
    logic [31:0]          load_word;
    logic                 store_en;

    // Upper address bits are dropped, so addresses wrap modulo the depth.
    assign word_idx = alu_result[ADDR_BITS+1:2];
    assign rd_word  = mem_q[word_idx];
    assign access   = mem_read | mem_write;

`ifdef MEM_BYTE_ACCESS_EN
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = rd_word[7:0];
        case (alu_result[1:0])
            2'b00:   sel_byte = rd_word[7:0];
            2'b01:   sel_byte = rd_word[15:8];
            2'b10:   sel_byte = rd_word[23:16];
            default: sel_byte = rd_word[31:24];
        endcase
        sel_half = alu_result[1] ? rd_word[31:16] : rd_word[15:0];
    end

    always_comb begin
        byte_en        = 4'hF;
        store_word     = write_data;
        load_word      = rd_word;
        misaligned_now = 1'b0;
        case (mem_size)
            2'b00: begin
                byte_en    = 4'b0001 << alu_result[1:0];
                store_word = {4{write_data[7:0]}};
                load_word  = mem_unsigned ? {24'b0, sel_byte}
                                          : {{24{sel_byte[7]}}, sel_byte};
            end
            2'b01: begin
                byte_en        = alu_result[1] ? 4'b1100 : 4'b0011;
                store_word     = {2{write_data[15:0]}};
                load_word      = mem_unsigned ? {16'b0, sel_half}
                                              : {{16{sel_half[15]}}, sel_half};
                misaligned_now = access & alu_result[0];
            end
            default: begin
                misaligned_now = access & (alu_result[1:0] != 2'b00);
            end
        endcase
    end
`else
    logic unused_size_bits;

    assign unused_size_bits = ^{mem_size, mem_unsigned};
    assign byte_en          = 4'hF;
    assign store_word       = write_data;
    assign load_word        = rd_word;
    assign misaligned_now   = access & (alu_result[1:0] != 2'b00);
`endif

    assign store_en = mem_write & ~stall & ~flush & ~rst & ~misaligned_now;

    // Data memory has no reset; its contents survive rst.
    always_ff @(posedge clk) begin
        if (store_en) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem_q[word_idx][8*i +: 8] <= store_word[8*i +: 8];
                end
            end
        end
    end

    logic [31:0] read_data_q, read_data_d;
    logic [31:0] alu_out_q, alu_out_d;
    logic [4:0]  rd_out_q, rd_out_d;
    logic        reg_write_out_q, reg_write_out_d;
    logic        mem_to_reg_out_q, mem_to_reg_out_d;
    logic        misaligned_q, misaligned_d;

    always_comb begin
        read_data_d      = read_data_q;
        alu_out_d        = alu_out_q;
        rd_out_d         = rd_out_q;
        reg_write_out_d  = reg_write_out_q;
        mem_to_reg_out_d = mem_to_reg_out_q;
        misaligned_d     = misaligned_q;
        if (flush) begin
            read_data_d      = 32'b0;
            alu_out_d        = 32'b0;
            rd_out_d         = 5'b0;
            reg_write_out_d  = 1'b0;
            mem_to_reg_out_d = 1'b0;
            misaligned_d     = 1'b0;
        end else if (!stall) begin
            read_data_d      = mem_read ? load_word : 32'b0;
            alu_out_d        = alu_result;
            rd_out_d         = rd_in;
            reg_write_out_d  = reg_write_in & ~misaligned_now;
            mem_to_reg_out_d = mem_to_reg_in & ~misaligned_now;
            misaligned_d     = misaligned_now;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read_data_q      <= 32'b0;
            alu_out_q        <= 32'b0;
            rd_out_q         <= 5'b0;
            reg_write_out_q  <= 1'b0;
            mem_to_reg_out_q <= 1'b0;
            misaligned_q     <= 1'b0;
        end else begin
            read_data_q      <= read_data_d;
            alu_out_q        <= alu_out_d;
            rd_out_q         <= rd_out_d;
            reg_write_out_q  <= reg_write_out_d;
            mem_to_reg_out_q <= mem_to_reg_out_d;
            misaligned_q     <= misaligned_d;
        end
    end

    assign read_data      = read_data_q;
    assign alu_out        = alu_out_q;
    assign rd_out         = rd_out_q;
    assign reg_write_out  = reg_write_out_q;
    assign mem_to_reg_out = mem_to_reg_out_q;
    assign misaligned     = misaligned_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: byte-addressed little-endian reference memory, directed steps then random traffic.
module tb_mem_stage;

    localparam int AB      = 8;
    localparam int DEPTH_B = 4 << AB;
    localparam int DEPTH_W = 1 << AB;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [4:0]  rd_in;
    logic        reg_write_in;
    logic        mem_to_reg_in;
    logic [31:0] read_data;
    logic [31:0] alu_out;
    logic [4:0]  rd_out;
    logic        reg_write_out;
    logic        mem_to_reg_out;
    logic        misaligned;

    mem_stage #(.ADDR_BITS(AB)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .alu_result(alu_result), .write_data(write_data),
        .rd_in(rd_in), .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
        .read_data(read_data), .alu_out(alu_out), .rd_out(rd_out),
        .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
        .misaligned(misaligned)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // reference model and scoreboard
    logic [7:0]  bmem [DEPTH_B];
    logic [71:0] exp_state = '0;
    logic [71:0] exp_q [$];
    int          vectors = 0;
    int          miscompares = 0;

    function automatic logic mis_of(logic r, logic w, logic [1:0] sz, logic [31:0] a);
        logic m;
`ifdef MEM_BYTE_ACCESS_EN
        if (sz == 2'b00)      m = 1'b0;
        else if (sz == 2'b01) m = a[0];
        else                  m = (a % 4) != 0;
`else
        m = (a % 4) != 0;
`endif
        return (r | w) & m;
    endfunction

    function automatic int unsigned nbytes(logic [1:0] sz);
`ifdef MEM_BYTE_ACCESS_EN
        if (sz == 2'b00) return 1;
        if (sz == 2'b01) return 2;
`endif
        return 4;
    endfunction

    function automatic logic [31:0] load_val(logic [31:0] a, logic [1:0] sz, logic uns);
        int unsigned n;
        int unsigned base;
        logic [31:0] v;
        n    = nbytes(sz);
        base = (a - (a % n)) % DEPTH_B;
        v    = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < n) v[8*i +: 8] = bmem[base + i];
        end
        if (!uns && n == 1) v = {{24{v[7]}}, v[7:0]};
        if (!uns && n == 2) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    function automatic logic [31:0] word_at(logic [31:0] a);
        return load_val(a, 2'b10, 1'b0);
    endfunction

    task automatic store_model(logic [31:0] a, logic [1:0] sz, logic [31:0] wd);
        int unsigned n;
        int unsigned base;
        n    = nbytes(sz);
        base = (a - (a % n)) % DEPTH_B;
        for (int i = 0; i < 4; i++) begin
            if (i < n) bmem[base + i] = wd[8*i +: 8];
        end
    endtask

    task automatic chk(string tag, logic [71:0] obs, logic [71:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one clock of the pipeline: predict, clock, compare
    task automatic step();
        logic m;
        logic do_store;
        m = mis_of(mem_read, mem_write, mem_size, alu_result);
        if (rst || flush) exp_state = '0;
        else if (!stall)
            exp_state = {(mem_read ? load_val(alu_result, mem_size, mem_unsigned) : 32'h0),
                         alu_result, rd_in, reg_write_in & ~m, mem_to_reg_in & ~m, m};
        do_store = !rst && !flush && !stall && mem_write && !m;
        exp_q.push_back(exp_state);
        @(posedge clk);
        if (do_store) store_model(alu_result, mem_size, write_data);
        #1;
        chk("cycle", {read_data, alu_out, rd_out, reg_write_out, mem_to_reg_out, misaligned},
            exp_q.pop_front());
    endtask

    // driver
    task automatic set_op(logic r, logic w, logic [1:0] sz, logic uns,
                          logic [31:0] a, logic [31:0] wd);
        rst           = 1'b0;
        stall         = 1'b0;
        flush         = 1'b0;
        mem_read      = r;
        mem_write     = w;
        mem_size      = sz;
        mem_unsigned  = uns;
        alu_result    = a;
        write_data    = wd;
        rd_in         = 5'($urandom);
        reg_write_in  = r;
        mem_to_reg_in = r;
    endtask

    task automatic set_random();
        set_op(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
        if ($urandom_range(0, 1) == 0) alu_result = alu_result & 32'h0000_007F;
        reg_write_in  = 1'($urandom);
        mem_to_reg_in = 1'($urandom);
    endtask

    logic [31:0] old_w;

    initial begin
        set_op(0, 0, 2'b10, 0, 0, 0);

        // reset with random inputs
        for (int i = 0; i < 2; i++) begin
            set_random();
            rst   = 1'b1;
            stall = 1'($urandom);
            flush = 1'($urandom);
            step();
            chk("rst_misaligned", misaligned, 0);
            chk("rst_read_data", read_data, 0);
        end

        // fill memory so the model knows every byte
        for (int i = 0; i < DEPTH_W; i++) begin
            set_op(0, 1, 2'b10, 0, 32'(i * 4), $urandom);
            step();
        end

        // word store then load
        set_op(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF); step();
        set_op(1, 0, 2'b10, 0, 32'h10, 0);            step();
        chk("lw_data", read_data, 32'hDEADBEEF);
        chk("lw_m2r", mem_to_reg_out, 1);
        chk("lw_alu", alu_out, 32'h10);

`ifdef MEM_BYTE_ACCESS_EN
        set_op(0, 1, 2'b00, 0, 32'h21, 32'h80); step();
        set_op(1, 0, 2'b00, 0, 32'h21, 0);      step();
        chk("lb", read_data, 32'hFFFFFF80);
        set_op(1, 0, 2'b00, 1, 32'h21, 0);      step();
        chk("lbu", read_data, 32'h00000080);
        set_op(1, 0, 2'b01, 0, 32'h20, 0);      step();
        chk("lh", read_data, {16'hFFFF, 8'h80, bmem[32]});
`endif

        // misaligned word store
        old_w = word_at(32'h0C);
        set_op(0, 1, 2'b10, 0, 32'h0E, 32'h12345678);
        reg_write_in  = 1'b1;
        mem_to_reg_in = 1'b1;
        step();
        chk("mis_flag", misaligned, 1);
        chk("mis_rw", reg_write_out, 0);
        set_op(1, 0, 2'b10, 0, 32'h0C, 0); step();
        chk("mis_clear", misaligned, 0);
        chk("mis_mem", read_data, old_w);

        // stall held three cycles
        set_op(0, 1, 2'b10, 0, 32'h30, 32'hCAFEF00D);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_alu", alu_out, 32'h0C);
            chk("stall_data", read_data, old_w);
        end
        stall = 1'b0; step();
        chk("stall_release", alu_out, 32'h30);
        set_op(1, 0, 2'b10, 0, 32'h30, 0); step();
        chk("stall_store", read_data, 32'hCAFEF00D);

        // flushed store
        old_w = word_at(32'h34);
        set_op(0, 1, 2'b10, 0, 32'h34, 32'hBAD0BAD0);
        reg_write_in = 1'b1;
        flush = 1'b1;
        step();
        chk("flush_alu", alu_out, 0);
        chk("flush_rw", reg_write_out, 0);
        set_op(1, 0, 2'b10, 0, 32'h34, 0); step();
        chk("flush_mem", read_data, old_w);

        // address wrap
        set_op(0, 1, 2'b10, 0, 32'h400, 32'h0A0B0C0D); step();
        set_op(1, 0, 2'b10, 0, 32'h000, 0);           step();
        chk("wrap", read_data, 32'h0A0B0C0D);

        // simultaneous read and write returns the old word
        old_w = word_at(32'h40);
        set_op(1, 1, 2'b10, 0, 32'h40, 32'h11112222); step();
        chk("rw_old", read_data, old_w);
        set_op(1, 0, 2'b10, 0, 32'h40, 0); step();
        chk("rw_new", read_data, 32'h11112222);

        // store dropped in a reset cycle
        old_w = word_at(32'h44);
        set_op(0, 1, 2'b10, 0, 32'h44, 32'h55);
        rst = 1'b1;
        step();
        chk("rst_alu", alu_out, 0);
        set_op(1, 0, 2'b10, 0, 32'h44, 0); step();
        chk("rst_store", read_data, old_w);

        // random traffic
        for (int i = 0; i < 500; i++) begin
            set_random();
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 11) == 0);
            rst   = ($urandom_range(0, 39) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
